// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one single-slot ALU between NR_REQ requesters
// Optional per-requester grant counters are built only when ALU_ARB_GRANT_CNT_EN is defined.
module alu_share_arbiter #(
  parameter int NR_REQ = 2,
  parameter int CNT_W  = 16,
  parameter int XLEN   = 32,
  parameter int OP_W   = 8,
  localparam int DATA_W = OP_W + 3 * XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [NR_REQ-1:0]        req_valid_i,
  output logic [NR_REQ-1:0]        req_ready_o,
  input  logic [NR_REQ*DATA_W-1:0] req_data_i,
  output logic [DATA_W-1:0]        alu_data_o,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic                     alu_branch_res_i,
  output logic [NR_REQ-1:0]        rsp_valid_o,
  input  logic [NR_REQ-1:0]        rsp_ready_i,
  output logic [XLEN-1:0]          rsp_result_o,
  output logic                     rsp_branch_o,
  output logic [NR_REQ*CNT_W-1:0]  grant_cnt_o
);

  localparam int IDX_W  = (NR_REQ > 2) ? 2 : 1;
  localparam int IDXP_W = IDX_W + 1;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_BUSY  = 1'b1;

  // Operation layout: {operation, operand_a, operand_b, imm}; an all-zero word is ADD 0+0.
  localparam logic [OP_W-1:0]   OP_ADD  = '0;
  localparam logic [DATA_W-1:0] OP_IDLE = {OP_ADD, {(3 * XLEN){1'b0}}};

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] op_q, op_d;

  logic [NR_REQ-1:0] owner_oh;
  logic [NR_REQ-1:0] grant_oh;
  logic              drain;
  logic              slot_free;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDXP_W-1:0] cand;
  logic [DATA_W-1:0] win_data;
  logic              grant;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (owner_q == IDX_W'(i)) owner_oh[i] = 1'b1;
    end
  end

  // Non-owner rsp_ready bits are masked off by the owner one-hot.
  assign drain     = (state_q == S_BUSY) && |(owner_oh & rsp_ready_i);
  assign slot_free = (state_q == S_EMPTY) || drain;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      cand = {1'b0, ptr_q} + IDXP_W'(k);
      if (cand >= IDXP_W'(NR_REQ)) cand = cand - IDXP_W'(NR_REQ);
      if (!win_found && req_valid_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = req_data_i[i*DATA_W +: DATA_W];
    end
  end

  assign grant = win_found && slot_free && !flush_i && !rst_i;

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (grant && (win_idx == IDX_W'(i))) grant_oh[i] = 1'b1;
    end
  end

  assign req_ready_o  = grant_oh;
  assign rsp_valid_o  = ((state_q == S_BUSY) && !rst_i) ? owner_oh : '0;
  assign rsp_result_o = alu_result_i;
  assign rsp_branch_o = alu_branch_res_i;
  assign alu_data_o   = op_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    if (flush_i) begin
      state_d = S_EMPTY;
      op_d    = OP_IDLE;
    end else if (grant) begin
      state_d = S_BUSY;
      owner_d = win_idx;
      op_d    = win_data;
      ptr_d   = (win_idx == IDX_W'(NR_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end else if (drain) begin
      state_d = S_EMPTY;
      op_d    = OP_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      owner_q <= '0;
      ptr_q   <= '0;
      op_q    <= OP_IDLE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
    end
  end

`ifdef ALU_ARB_GRANT_CNT_EN
  for (genvar g = 0; g < NR_REQ; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturate rather than wrap so a long-running requester never reads as starved.
    always_comb begin
      cnt_d = cnt_q;
      if (grant_oh[g] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign grant_cnt_o[g*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign grant_cnt_o = '0;
`endif

  a_ready_onehot: assert property (@(posedge clk_i) $onehot0(req_ready_o));
  a_rsp_onehot:   assert property (@(posedge clk_i) $onehot0(rsp_valid_o));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
// Expected counter values follow ALU_ARB_GRANT_CNT_EN.
module tb_alu_share_arbiter;

  localparam int NR_REQ = 2;
  localparam int CNT_W  = 4;
  localparam int XLEN   = 32;
  localparam int OP_W   = 8;
  localparam int DATA_W = OP_W + 3 * XLEN;

  localparam logic [OP_W-1:0] OP_ADD = 8'd0;
  localparam logic [OP_W-1:0] OP_SUB = 8'd1;
  localparam logic [OP_W-1:0] OP_BEQ = 8'd2;

`ifdef ALU_ARB_GRANT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                     clk;
  logic                     rst;
  logic                     flush;
  logic [NR_REQ-1:0]        req_valid;
  logic [NR_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]        req_data0, req_data1;
  logic [DATA_W-1:0]        alu_data;
  logic [XLEN-1:0]          alu_result;
  logic                     alu_branch;
  logic [NR_REQ-1:0]        rsp_valid;
  logic [NR_REQ-1:0]        rsp_ready;
  logic [XLEN-1:0]          rsp_result;
  logic                     rsp_branch;
  logic [NR_REQ*CNT_W-1:0]  grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(
    .NR_REQ(NR_REQ), .CNT_W(CNT_W), .XLEN(XLEN), .OP_W(OP_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_data_i      ({req_data1, req_data0}),
    .alu_data_o      (alu_data),
    .alu_result_i    (alu_result),
    .alu_branch_res_i(alu_branch),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .rsp_branch_o    (rsp_branch),
    .grant_cnt_o     (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU attached to the arbiter's output.
  always_comb begin
    alu_result = '0;
    alu_branch = 1'b0;
    case (alu_data[DATA_W-1 -: OP_W])
      OP_ADD:  alu_result = alu_data[3*XLEN-1 -: XLEN] + alu_data[2*XLEN-1 -: XLEN];
      OP_SUB:  alu_result = alu_data[3*XLEN-1 -: XLEN] - alu_data[2*XLEN-1 -: XLEN];
      OP_BEQ:  alu_branch = (alu_data[3*XLEN-1 -: XLEN] == alu_data[2*XLEN-1 -: XLEN]);
      default: alu_result = '0;
    endcase
  end

  function automatic logic [DATA_W-1:0] mk_op(input logic [OP_W-1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    return {op, a, b, {XLEN{1'b0}}};
  endfunction

  function automatic logic [7:0] exp_cnt(input logic [3:0] c1, input logic [3:0] c0);
    return CNT_EN ? {c1, c0} : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_data0 = mk_op(OP_ADD, 32'd9, 32'd9);
    req_data1 = mk_op(OP_ADD, 32'd9, 32'd9);

    // Reset: ready and response both suppressed during the reset cycle.
    tick();
    tick();
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_cnt", grant_cnt, 8'h00);
    check("rst_alu_data", alu_data, '0);
    rst = 1'b0;

    // Both requesters always valid: grants alternate, one result per cycle.
    req_data0 = mk_op(OP_ADD, 32'd1, 32'd2);
    req_data1 = mk_op(OP_ADD, 32'd10, 32'd20);
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_rsp_valid", rsp_valid, (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10));
      if (i > 0) check("rr_result", rsp_result, (i % 2 == 1) ? 32'd3 : 32'd30);
      tick();
    end
    req_valid = 2'b00;
    #1;
    check("rr_last_valid", rsp_valid, 2'b10);
    check("rr_last_result", rsp_result, 32'd30);
    check("rr_last_ready", req_ready, 2'b00);
    tick();
    check("rr_empty_valid", rsp_valid, 2'b00);
    check("rr_empty_alu", alu_data, '0);
    check("rr_cnt", grant_cnt, exp_cnt(4'd2, 4'd2));

    // Stalled response: result held, new requests blocked.
    req_valid = 2'b01;
    req_data0 = mk_op(OP_ADD, 32'd5, 32'd7);
    rsp_ready = 2'b00;
    #1;
    check("stall_grant", req_ready, 2'b01);
    tick();
    req_data0 = mk_op(OP_ADD, 32'd100, 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", rsp_valid, 2'b01);
      check("stall_result", rsp_result, 32'd12);
      check("stall_ready", req_ready, 2'b00);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    #1;
    check("stall_rel_valid", rsp_valid, 2'b01);
    check("stall_rel_result", rsp_result, 32'd12);
    tick();
    check("stall_done", rsp_valid, 2'b00);

    // Branch from requester 1; wrong-owner ready must not release it.
    req_valid = 2'b10;
    req_data1 = mk_op(OP_BEQ, 32'd4, 32'd4);
    rsp_ready = 2'b01;
    #1;
    check("beq_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("beq_valid", rsp_valid, 2'b10);
      check("beq_branch", rsp_branch, 1'b1);
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    check("beq_rel_valid", rsp_valid, 2'b10);
    tick();
    check("beq_done", rsp_valid, 2'b00);

    // Flush while requester 1 is busy.
    req_valid = 2'b10;
    req_data1 = mk_op(OP_SUB, 32'd10, 32'd3);
    rsp_ready = 2'b00;
    #1;
    check("fl_grant1", req_ready, 2'b10);
    tick();
    flush     = 1'b1;
    req_valid = 2'b01;
    req_data0 = mk_op(OP_ADD, 32'd1, 32'd1);
    #1;
    check("fl_blocked", req_ready, 2'b00);
    check("fl_cur_valid", rsp_valid, 2'b10);
    check("fl_cur_result", rsp_result, 32'd7);
    tick();
    flush = 1'b0;
    #1;
    check("fl_empty_valid", rsp_valid, 2'b00);
    check("fl_empty_alu", alu_data, '0);
    check("fl_grant0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    #1;
    check("fl_rsp0_valid", rsp_valid, 2'b01);
    check("fl_rsp0_result", rsp_result, 32'd2);
    tick();
    check("fl_cnt", grant_cnt, exp_cnt(4'd4, 4'd4));

    // Requester 0 alone for 20 back-to-back transfers: counter saturates.
    req_valid = 2'b01;
    req_data0 = mk_op(OP_ADD, 32'd3, 32'd3);
    rsp_ready = 2'b11;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("sat_ready", req_ready, 2'b01);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    check("sat_busy_valid", rsp_valid, 2'b01);
    check("sat_cnt", grant_cnt, exp_cnt(4'd4, 4'd15));

    // Reset while busy: response discarded, pointer and counters cleared.
    rst       = 1'b1;
    req_valid = 2'b01;
    #1;
    check("mrst_valid", rsp_valid, 2'b00);
    check("mrst_ready", req_ready, 2'b00);
    tick();
    rst       = 1'b0;
    req_valid = 2'b11;
    #1;
    check("mrst_after_valid", rsp_valid, 2'b00);
    check("mrst_after_cnt", grant_cnt, 8'h00);
    check("mrst_after_alu", alu_data, '0);
    check("mrst_ptr0", req_ready, 2'b01);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
